// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
// Holds a 16-bit word on the data inputs of an external 16:1 mux and walks
// the mux select through all 16 positions. The bit that comes back on
// mux_out is registered and presented as a serial stream.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high reset, highest priority
//   load       : start a scan of data_in (honoured only in IDLE)
//   data_in    : parallel word to serialize
//   stop       : abort a scan in progress (beats load in IDLE)
//   mux_out    : selected bit returned by the external mux
//   in16       : held word driven to the mux data inputs
//   sel4       : registered mux select index
//   ser_out    : registered serial bit
//   ser_valid  : one-cycle strobe, ser_out carries a new bit
//   busy       : high while scanning
//   done       : one-cycle strobe, scan finished normally
module mux_scan_serializer #(
   parameter int BIT_TICKS = 1,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] data_in,
   input  logic        stop,
   input  logic        mux_out,
   output logic [15:0] in16,
   output logic [3:0]  sel4,
   output logic        ser_out,
   output logic        ser_valid,
   output logic        busy,
   output logic        done
);

   localparam int            TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [3:0]    SEL_FIRST = LSB_FIRST ? 4'd0 : 4'd15;
   // The 16th sample is taken while sel4 sits on the final index.
   localparam logic [3:0]    SEL_LAST  = LSB_FIRST ? 4'd15 : 4'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   in16_q, in16_d;
   logic [3:0]    sel4_q, sel4_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          ser_out_q, ser_out_d;
   logic          ser_valid_q, ser_valid_d;

   // Next-state and datapath decode.
   always_comb begin
      state_d     = state_q;
      in16_d      = in16_q;
      sel4_d      = sel4_q;
      tick_d      = tick_q;
      ser_out_d   = ser_out_q;
      ser_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (load && !stop) begin
               in16_d  = data_in;
               sel4_d  = SEL_FIRST;
               tick_d  = {TW{1'b0}};
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // Abort wins over a sample falling on the same edge; all
            // datapath registers keep their values.
            if (stop) begin
               state_d = IDLE;
            end else if (tick_q == TICK_LAST) begin
               tick_d      = {TW{1'b0}};
               ser_out_d   = mux_out;
               ser_valid_d = 1'b1;
               if (sel4_q == SEL_LAST) begin
                  state_d = DONE;
               end else if (LSB_FIRST) begin
                  sel4_d = sel4_q + 4'd1;
               end else begin
                  sel4_d = sel4_q - 4'd1;
               end
            end else begin
               tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in16_q      <= 16'h0000;
         sel4_q      <= 4'd0;
         tick_q      <= {TW{1'b0}};
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in16_q      <= in16_d;
         sel4_q      <= sel4_d;
         tick_q      <= tick_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
      end
   end

   assign in16      = in16_q;
   assign sel4      = sel4_q;
   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);

endmodule
